// File: rtl/demux_pkg.sv
// Shared helpers for the stream demultiplexer.
// sel_width gives the channel-select width: at least one bit, even for degenerate N.
package demux_pkg;

    function automatic int sel_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register for a single demux channel.
// A load always wins over a drain, so a word can pass straight through in one cycle.
module demux_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] din_i,
    input  logic         drain_ready_i,
    output logic         valid_o,
    output logic [W-1:0] dout_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = din_i;
        end else if (valid_q && drain_ready_i) begin
            // Data keeps its last value after a drain.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign dout_o  = data_q;

endmodule

// File: rtl/demux_stream.sv
// Registered 1:N stream demultiplexer with valid/ready handshake.
// Each channel has its own one-entry slot, so a stalled consumer only blocks words aimed at it.
module demux_stream
    import demux_pkg::*;
#(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int SEL_W = sel_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W-1:0]     in_data_i,
    input  logic [SEL_W-1:0] in_sel_i,
    output logic [N-1:0]     out_valid_o,
    input  logic [N-1:0]     out_ready_i,
    output logic [N*W-1:0]   out_data_o,
    output logic             drop_o
);

    logic [N-1:0] sel_oh;
    logic [N-1:0] load;
    logic         sel_ok;
    logic         drop_q, drop_d;

    // An all-zero decode means the select points past the last channel.
    assign sel_ok     = |sel_oh;
    assign in_ready_o = !sel_ok || |(sel_oh & (~out_valid_o | out_ready_i));
    assign drop_d     = in_valid_i && !sel_ok;

    for (genvar k = 0; k < N; k++) begin : g_slot
        assign sel_oh[k] = (in_sel_i == SEL_W'(k));
        assign load[k]   = in_valid_i && in_ready_o && sel_oh[k];

        demux_slot #(.W(W)) u_slot (
            .clk           (clk),
            .rst           (rst),
            .load_i        (load[k]),
            .din_i         (in_data_i),
            .drain_ready_i (out_ready_i[k]),
            .valid_o       (out_valid_o[k]),
            .dout_o        (out_data_o[k*W +: W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) drop_q <= 1'b0;
        else     drop_q <= drop_d;
    end

    assign drop_o = drop_q;

endmodule
